// File: rtl/rob_commit_if.sv
// Bundle between the reorder buffer and the commit stage. The ROB side drives
// the per-entry state; the commit stage drives the pointer, retire count,
// register-file write ports and the flush pulse.
interface rob_commit_if #(
    parameter int RETIRE_W = 3
);
    logic [3:0]              rob_head;
    logic [15:0]             rob_finished;
    logic [15:0]             rob_exc;
    logic [255:0]            rob_values;
    logic [63:0]             rob_dest;

    logic [3:0]              commit_ptr;
    logic [2:0]              retire_count;
    logic [RETIRE_W-1:0]     rf_we;
    logic [4*RETIRE_W-1:0]   rf_waddr;
    logic [16*RETIRE_W-1:0]  rf_wdata;
    logic                    flush;
    logic [3:0]              flush_idx;

    modport master (
        output rob_head, rob_finished, rob_exc, rob_values, rob_dest,
        input  commit_ptr, retire_count, rf_we, rf_waddr, rf_wdata, flush, flush_idx
    );

    modport slave (
        input  rob_head, rob_finished, rob_exc, rob_values, rob_dest,
        output commit_ptr, retire_count, rf_we, rf_waddr, rf_wdata, flush, flush_idx
    );
endinterface

// File: rtl/rob_commit.sv
// In-order commit stage. S1 picks up to RETIRE_W consecutive finished,
// non-excepting entries starting at the ROB tail; S2 registers drive the
// register-file write ports one cycle later. An excepting entry at the tail
// is retired alone and turns into a flush pulse, followed by a short drain.
// FLUSH_LAT is expected to be at least 1.
module rob_commit #(
    parameter int RETIRE_W  = 3,
    parameter int FLUSH_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    rob_commit_if.slave bus
);
    localparam int CW = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          drain_cnt, drain_cnt_next;

    logic [3:0]             commit_ptr_q, commit_ptr_next;
    logic [2:0]             retire_count_q, retire_count_next;
    logic [RETIRE_W-1:0]    rf_we_q, rf_we_next;
    logic [4*RETIRE_W-1:0]  rf_waddr_q, rf_waddr_next;
    logic [16*RETIRE_W-1:0] rf_wdata_q, rf_wdata_next;
    logic                   flush_q, flush_next;
    logic [3:0]             flush_idx_q, flush_idx_next;

    logic [3:0]             occ;
    logic [3:0]             port_idx  [RETIRE_W];
    logic [3:0]             port_addr [RETIRE_W];
    logic [15:0]            port_data [RETIRE_W];
    logic [RETIRE_W-1:0]    port_ok;
    logic [2:0]             sel_n;
    logic                   exc_sel;
    logic [RETIRE_W-1:0]    we_sel;

    assign occ = bus.rob_head - commit_ptr_q;

    // Per-port view of the entry that port k would retire this cycle.
    for (genvar k = 0; k < RETIRE_W; k++) begin : g_port
        assign port_idx[k]  = commit_ptr_q + 4'(k);
        assign port_addr[k] = bus.rob_dest[4*port_idx[k] +: 4];
        assign port_data[k] = bus.rob_values[16*port_idx[k] +: 16];
        assign port_ok[k]   = (4'(k) < occ) && bus.rob_finished[port_idx[k]]
                              && !bus.rob_exc[port_idx[k]];
    end

    // Count the unbroken run of retirable entries from the tail; an excepting
    // tail entry only forms its own group when nothing ahead of it retires.
    always_comb begin
        logic chain;
        sel_n = 3'd0;
        chain = 1'b1;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (chain && port_ok[k]) begin
                sel_n = sel_n + 3'd1;
            end else begin
                chain = 1'b0;
            end
        end
        exc_sel = (sel_n == 3'd0) && (occ != 4'd0)
                  && bus.rob_finished[commit_ptr_q] && bus.rob_exc[commit_ptr_q];
    end

    // Same-group WAW: a port loses its write when a younger selected port
    // targets the same architectural register.
    always_comb begin
        we_sel = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            we_sel[k] = (3'(k) < sel_n);
            for (int j = k + 1; j < RETIRE_W; j++) begin
                if ((3'(j) < sel_n) && (port_addr[j] == port_addr[k])) begin
                    we_sel[k] = 1'b0;
                end
            end
        end
    end

    // Next-state and next S2 contents; S1 only selects while in RUN.
    always_comb begin
        state_next        = state;
        drain_cnt_next    = drain_cnt;
        commit_ptr_next   = commit_ptr_q;
        retire_count_next = 3'd0;
        rf_we_next        = '0;
        rf_waddr_next     = '0;
        rf_wdata_next     = '0;
        flush_next        = 1'b0;
        flush_idx_next    = 4'd0;
        case (state)
            RUN: begin
                if (exc_sel) begin
                    commit_ptr_next   = commit_ptr_q + 4'd1;
                    retire_count_next = 3'd1;
                    flush_next        = 1'b1;
                    flush_idx_next    = commit_ptr_q;
                    state_next        = FLUSH;
                end else begin
                    commit_ptr_next   = commit_ptr_q + {1'b0, sel_n};
                    retire_count_next = sel_n;
                    rf_we_next        = we_sel;
                    for (int k = 0; k < RETIRE_W; k++) begin
                        rf_waddr_next[4*k +: 4]   = port_addr[k];
                        rf_wdata_next[16*k +: 16] = port_data[k];
                    end
                end
            end
            FLUSH: begin
                commit_ptr_next = bus.rob_head;
                drain_cnt_next  = CW'(FLUSH_LAT - 1);
                state_next      = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = RUN;
                end else begin
                    drain_cnt_next = drain_cnt - 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // FSM state and drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // Commit pointer and S2 write-stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_ptr_q   <= 4'd0;
            retire_count_q <= 3'd0;
            rf_we_q        <= '0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            flush_q        <= 1'b0;
            flush_idx_q    <= 4'd0;
        end else begin
            commit_ptr_q   <= commit_ptr_next;
            retire_count_q <= retire_count_next;
            rf_we_q        <= rf_we_next;
            rf_waddr_q     <= rf_waddr_next;
            rf_wdata_q     <= rf_wdata_next;
            flush_q        <= flush_next;
            flush_idx_q    <= flush_idx_next;
        end
    end

    assign bus.commit_ptr   = commit_ptr_q;
    assign bus.retire_count = retire_count_q;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.flush        = flush_q;
    assign bus.flush_idx    = flush_idx_q;
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: each step drives the ROB view, pushes the
// expected S2 outputs to a scoreboard and pops/compares them after the edge.
module tb_rob_commit;
    localparam int RW = 3;
    localparam int FL = 2;

    logic clk;
    logic rst;

    rob_commit_if #(.RETIRE_W(RW)) bus ();

    rob_commit #(.RETIRE_W(RW), .FLUSH_LAT(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  rc;
        logic [2:0]  we;
        logic [11:0] waddr;
        logic [47:0] wdata;
        logic        flush;
        logic [3:0]  fidx;
        logic [3:0]  cp;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [3:0]  head;
    logic [15:0] fin;
    logic [15:0] exc;
    logic [15:0] vals [16];
    logic [3:0]  dst  [16];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic apply_stimulus();
        bus.rob_head     = head;
        bus.rob_finished = fin;
        bus.rob_exc      = exc;
        for (int i = 0; i < 16; i++) begin
            bus.rob_values[16*i +: 16] = vals[i];
            bus.rob_dest[4*i +: 4]     = dst[i];
        end
    endtask

    task automatic check_output();
        exp_t e;
        logic [11:0] amask;
        logic [47:0] dmask;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        amask = '0;
        dmask = '0;
        for (int k = 0; k < RW; k++) begin
            if (e.we[k]) begin
                amask[4*k +: 4]   = 4'hF;
                dmask[16*k +: 16] = 16'hFFFF;
            end
        end
        check("retire_count", 64'(bus.retire_count), 64'(e.rc));
        check("rf_we", 64'(bus.rf_we), 64'(e.we));
        check("commit_ptr", 64'(bus.commit_ptr), 64'(e.cp));
        check("flush", 64'(bus.flush), 64'(e.flush));
        if (e.flush) check("flush_idx", 64'(bus.flush_idx), 64'(e.fidx));
        if (e.we != 3'd0) begin
            check("rf_waddr", 64'(bus.rf_waddr & amask), 64'(e.waddr));
            check("rf_wdata", 64'(bus.rf_wdata & dmask), 64'(e.wdata));
        end
    endtask

    task automatic step(input logic [2:0] rc, input logic [2:0] we, input logic [11:0] waddr,
                        input logic [47:0] wdata, input logic flush, input logic [3:0] fidx,
                        input logic [3:0] cp);
        exp_t e;
        apply_stimulus();
        e.rc = rc; e.we = we; e.waddr = waddr; e.wdata = wdata;
        e.flush = flush; e.fidx = fidx; e.cp = cp;
        sb.push_back(e);
        check_output();
    endtask

    // Directed sequence covering reset, retire, gaps, wrap/WAW, exception and reset in DRAIN.
    initial begin
        for (int i = 0; i < 16; i++) begin
            vals[i] = 16'h0;
            dst[i]  = 4'h0;
        end
        exc = 16'h0;

        // Reset held two cycles with live-looking ROB inputs.
        vals[0] = 16'h00A0; dst[0] = 4'd1;
        vals[1] = 16'h00A1; dst[1] = 4'd2;
        vals[2] = 16'h00A2; dst[2] = 4'd3;
        vals[3] = 16'h00A3; dst[3] = 4'd4;
        head = 4'd4;
        fin  = 16'h001F;
        rst  = 1'b1;
        $display("[TB] reset");
        step(3'd0, 3'b000, 12'h0, 48'h0, 1'b0, 4'd0, 4'd0);
        step(3'd0, 3'b000, 12'h0, 48'h0, 1'b0, 4'd0, 4'd0);
        rst = 1'b0;

        // Basic retire; entry 4 is finished but beyond rob_head.
        $display("[TB] basic retire");
        step(3'd3, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h00A2, 16'h00A1, 16'h00A0}, 1'b0, 4'd0, 4'd3);
        step(3'd1, 3'b001, {4'd0, 4'd0, 4'd4}, {16'h0, 16'h0, 16'h00A3}, 1'b0, 4'd0, 4'd4);
        step(3'd0, 3'b000, 12'h0, 48'h0, 1'b0, 4'd0, 4'd4);

        // Gap: entry 6 waits for entry 5.
        $display("[TB] gap");
        vals[4] = 16'h00B4; dst[4] = 4'd6;
        vals[5] = 16'h00B5; dst[5] = 4'd7;
        vals[6] = 16'h00B6; dst[6] = 4'd8;
        head = 4'd7;
        fin  = 16'h0050;
        step(3'd1, 3'b001, {4'd0, 4'd0, 4'd6}, {16'h0, 16'h0, 16'h00B4}, 1'b0, 4'd0, 4'd5);
        step(3'd0, 3'b000, 12'h0, 48'h0, 1'b0, 4'd0, 4'd5);
        fin  = 16'h0070;
        step(3'd2, 3'b011, {4'd0, 4'd8, 4'd7}, {16'h0, 16'h00B6, 16'h00B5}, 1'b0, 4'd0, 4'd7);

        // Advance the tail to 14.
        for (int i = 7; i < 14; i++) begin
            vals[i] = 16'h00C0 + 16'(i);
            dst[i]  = 4'(i);
        end
        head = 4'd14;
        fin  = 16'h3F80;
        step(3'd3, 3'b111, {4'd9, 4'd8, 4'd7}, {16'h00C9, 16'h00C8, 16'h00C7}, 1'b0, 4'd0, 4'd10);
        step(3'd3, 3'b111, {4'hC, 4'hB, 4'hA}, {16'h00CC, 16'h00CB, 16'h00CA}, 1'b0, 4'd0, 4'd13);
        step(3'd1, 3'b001, {4'd0, 4'd0, 4'hD}, {16'h0, 16'h0, 16'h00CD}, 1'b0, 4'd0, 4'd14);

        // Wrap with all three ports targeting r5: only the youngest writes.
        $display("[TB] wrap and WAW");
        vals[14] = 16'h0D14; dst[14] = 4'd5;
        vals[15] = 16'h0D15; dst[15] = 4'd5;
        vals[0]  = 16'h0D00; dst[0]  = 4'd5;
        head = 4'd1;
        fin  = 16'hC001;
        step(3'd3, 3'b100, {4'd5, 4'd0, 4'd0}, {16'h0D00, 16'h0, 16'h0}, 1'b0, 4'd0, 4'd1);
        step(3'd0, 3'b000, 12'h0, 48'h0, 1'b0, 4'd0, 4'd1);

        // Exception behind a finished entry, then flush and drain.
        $display("[TB] exception");
        vals[1] = 16'h00E1; dst[1] = 4'd9;
        head = 4'd7;
        fin  = 16'h0006;
        exc  = 16'h0004;
        step(3'd1, 3'b001, {4'd0, 4'd0, 4'd9}, {16'h0, 16'h0, 16'h00E1}, 1'b0, 4'd0, 4'd2);
        step(3'd1, 3'b000, 12'h0, 48'h0, 1'b1, 4'd2, 4'd3);
        vals[7] = 16'h00F7; dst[7] = 4'd3;
        vals[8] = 16'h00F8; dst[8] = 4'd4;
        fin  = 16'h0186;
        step(3'd0, 3'b000, 12'h0, 48'h0, 1'b0, 4'd0, 4'd7);
        head = 4'd12;
        step(3'd0, 3'b000, 12'h0, 48'h0, 1'b0, 4'd0, 4'd7);
        step(3'd0, 3'b000, 12'h0, 48'h0, 1'b0, 4'd0, 4'd7);
        step(3'd2, 3'b011, {4'd0, 4'd4, 4'd3}, {16'h0, 16'h00F8, 16'h00F7}, 1'b0, 4'd0, 4'd9);

        // Second exception, reset asserted in the first DRAIN cycle.
        $display("[TB] reset during drain");
        fin = 16'h0200;
        exc = 16'h0200;
        step(3'd1, 3'b000, 12'h0, 48'h0, 1'b1, 4'd9, 4'd10);
        step(3'd0, 3'b000, 12'h0, 48'h0, 1'b0, 4'd0, 4'd12);
        rst = 1'b1;
        step(3'd0, 3'b000, 12'h0, 48'h0, 1'b0, 4'd0, 4'd0);
        rst = 1'b0;
        vals[0] = 16'h1111; dst[0] = 4'd6;
        vals[1] = 16'h2222; dst[1] = 4'd6;
        head = 4'd2;
        fin  = 16'h0003;
        exc  = 16'h0000;
        step(3'd2, 3'b010, {4'd0, 4'd6, 4'd0}, {16'h0, 16'h2222, 16'h0}, 1'b0, 4'd0, 4'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
